// File: rtl/hazard_unit_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_mc_if
// Brief    : Signal bundle between the pipeline datapath and the hazard unit.
//            The datapath side (master) drives stage information and receives
//            stall/flush/forward controls. The hazard-unit side (slave) is the
//            reverse. StallCount exists only when HAZ_STALL_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_unit_mc_if #(
  parameter int REG_W = 5
);
  // Stage information from the datapath
  logic             BranchD;
  logic [REG_W-1:0] RsD;
  logic [REG_W-1:0] RtD;
  logic [REG_W-1:0] RsE;
  logic [REG_W-1:0] RtE;
  logic [REG_W-1:0] WriteRegE;
  logic [REG_W-1:0] WriteRegM;
  logic [REG_W-1:0] WriteRegW;
  logic             RegWriteE;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             MemtoRegE;
  logic             MemtoRegM;
  logic             MduStartE;
  logic             MduIsDivE;
  logic             MduOpD;

  // Pipeline control back to the datapath
  logic             StallF;
  logic             StallD;
  logic             FlushE;
  logic             ForwardAD;
  logic             ForwardBD;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             MduBusy;
`ifdef HAZ_STALL_CNT_EN
  logic [31:0]      StallCount;
`endif

  modport master (
    output BranchD, RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    output MduStartE, MduIsDivE, MduOpD,
`ifdef HAZ_STALL_CNT_EN
    input  StallCount,
`endif
    input  StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
    input  MduBusy
  );

  modport slave (
    input  BranchD, RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    input  MduStartE, MduIsDivE, MduOpD,
`ifdef HAZ_STALL_CNT_EN
    output StallCount,
`endif
    output StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
    output MduBusy
  );
endinterface
`default_nettype wire

// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_mc
// Brief    : Hazard unit for the 5-stage MIPS pipeline. Combinational
//            forwarding and load-use/branch stall detection, plus a tracker
//            for the multi-cycle multiply/divide unit that holds dependent
//            instructions in D until the MDU result is ready.
//            Optional feature macro: HAZ_STALL_CNT_EN adds a saturating
//            32-bit stall-cycle counter on StallCount.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit_mc #(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  hazard_unit_mc_if.slave   hz
);

  localparam int c_maxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int c_cntW   = $clog2(c_maxLat + 1);
  // Counter holds LAT-1 so that BUSY lasts exactly LAT cycles
  localparam logic [c_cntW-1:0] c_mulLoad = c_cntW'(MUL_LAT - 1);
  localparam logic [c_cntW-1:0] c_divLoad = c_cntW'(DIV_LAT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mduState_t;

  mduState_t         r_state;
  logic [c_cntW-1:0] r_cnt;
  logic              r_mduBusy;

  logic [1:0]        w_fwdAE;
  logic [1:0]        w_fwdBE;
  logic              w_fwdAD;
  logic              w_fwdBD;
  logic              w_lwStall;
  logic              w_brStall;
  logic              w_mduStall;
  logic              w_stall;

  // Forwarding selects: M-stage result wins over W-stage result; $zero never forwards
  always_comb begin
    w_fwdAE = 2'b00;
    w_fwdBE = 2'b00;
    if ((hz.RsE != '0) && hz.RegWriteM && (hz.WriteRegM == hz.RsE))
      w_fwdAE = 2'b10;
    else if ((hz.RsE != '0) && hz.RegWriteW && (hz.WriteRegW == hz.RsE))
      w_fwdAE = 2'b01;
    if ((hz.RtE != '0) && hz.RegWriteM && (hz.WriteRegM == hz.RtE))
      w_fwdBE = 2'b10;
    else if ((hz.RtE != '0) && hz.RegWriteW && (hz.WriteRegW == hz.RtE))
      w_fwdBE = 2'b01;
    w_fwdAD = (hz.RsD != '0) && hz.RegWriteM && (hz.WriteRegM == hz.RsD);
    w_fwdBD = (hz.RtD != '0) && hz.RegWriteM && (hz.WriteRegM == hz.RtD);
  end

  // Stall sources are OR-ed so overlapping hazards give a single stall
  always_comb begin
    w_lwStall  = hz.MemtoRegE && ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));
    w_brStall  = hz.BranchD &&
                 ((hz.RegWriteE && ((hz.WriteRegE == hz.RsD) || (hz.WriteRegE == hz.RtD))) ||
                  (hz.MemtoRegM && ((hz.WriteRegM == hz.RsD) || (hz.WriteRegM == hz.RtD))));
    // An MDU op entering E this cycle already blocks a dependent D instruction
    w_mduStall = hz.MduOpD && (r_mduBusy || hz.MduStartE);
    w_stall    = w_lwStall || w_brStall || w_mduStall;
  end

  // MDU tracker: a start in IDLE loads the latency; a start while BUSY is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_mduBusy <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (hz.MduStartE) begin
            r_cnt     <= hz.MduIsDivE ? c_divLoad : c_mulLoad;
            r_state   <= BUSY;
            r_mduBusy <= 1'b1;
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_state   <= IDLE;
            r_mduBusy <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mduBusy <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [31:0] r_stallCount;

  // Count stalled cycles, sticking at all-ones rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stallCount <= '0;
    else if (w_stall && (r_stallCount != 32'hFFFF_FFFF))
      r_stallCount <= r_stallCount + 32'd1;
  end

  assign hz.StallCount = r_stallCount;
`endif

  assign hz.StallF    = w_stall;
  assign hz.StallD    = w_stall;
  assign hz.FlushE    = w_stall;
  assign hz.ForwardAE = w_fwdAE;
  assign hz.ForwardBE = w_fwdBE;
  assign hz.ForwardAD = w_fwdAD;
  assign hz.ForwardBD = w_fwdBD;
  assign hz.MduBusy   = r_mduBusy;

endmodule
`default_nettype wire
